// File: rtl/fetch_unit_param_if.sv
// rtl/fetch_unit_param_if.sv - control/imem-side bundle for the fetch PC sequencer
interface fetch_unit_param_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 32
);
    logic             start;
    logic [PC_W-1:0]  start_addr;
    logic             taken;
    logic [PC_W-1:0]  target;
    logic             halt;
    logic             stall;
    logic [PC_W-1:0]  pc_o;
    logic             running_o;
    logic             halted_o;
    logic [CNT_W-1:0] cycle_cnt_o;
    logic [CNT_W-1:0] fetch_cnt_o;

    modport master (
        output start, start_addr, taken, target, halt, stall,
        input  pc_o, running_o, halted_o, cycle_cnt_o, fetch_cnt_o
    );

    modport slave (
        input  start, start_addr, taken, target, halt, stall,
        output pc_o, running_o, halted_o, cycle_cnt_o, fetch_cnt_o
    );
endinterface

// File: rtl/fetch_unit_param.sv
// rtl/fetch_unit_param.sv - PC sequencer with stall-latched redirect, halt and perf counters
// Optional feature macro: FETCH_PERF_CNT_EN builds the saturating cycle/fetch counters.
module fetch_unit_param #(
    parameter int PC_W   = 8,
    parameter int PC_INC = 1,
    parameter int CNT_W  = 32
) (
    input  logic                 f_clk,
    input  logic                 f_reset,
    fetch_unit_param_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            pend_vld_q, pend_vld_d;
    logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;

    always_ff @(posedge f_clk) begin
        if (f_reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = S_RUN;
        end else if (state_q == S_RUN && bus.halt) begin
            state_d = S_HALTED;
        end
    end

    // Live target beats a latched one; a stalled taken only updates the latch.
    always_comb begin
        pc_d       = pc_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        if (bus.start) begin
            pc_d       = bus.start_addr;
            pend_vld_d = 1'b0;
        end else if (state_q == S_RUN) begin
            if (bus.halt) begin
                pend_vld_d = 1'b0;
            end else if (bus.stall) begin
                if (bus.taken) begin
                    pend_tgt_d = bus.target;
                    pend_vld_d = 1'b1;
                end
            end else if (bus.taken) begin
                pc_d       = bus.target;
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                pc_d       = pend_tgt_q;
                pend_vld_d = 1'b0;
            end else begin
                pc_d = pc_q + PC_W'(PC_INC);
            end
        end
    end

    always_comb begin
        bus.pc_o      = pc_q;
        bus.running_o = (state_q == S_RUN);
        bus.halted_o  = (state_q == S_HALTED);
    end

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_cnt_q;
    logic [CNT_W-1:0] fch_cnt_q;
    logic             run_tick;
    logic             fetch_tick;

    assign run_tick   = (state_q == S_RUN) && !bus.halt;
    assign fetch_tick = run_tick && !bus.stall;

    always_ff @(posedge f_clk) begin
        if (f_reset || bus.start) begin
            cyc_cnt_q <= '0;
            fch_cnt_q <= '0;
        end else begin
            if (run_tick && (cyc_cnt_q != '1)) begin
                cyc_cnt_q <= cyc_cnt_q + 1'b1;
            end
            if (fetch_tick && (fch_cnt_q != '1)) begin
                fch_cnt_q <= fch_cnt_q + 1'b1;
            end
        end
    end

    assign bus.cycle_cnt_o = cyc_cnt_q;
    assign bus.fetch_cnt_o = fch_cnt_q;
`else
    assign bus.cycle_cnt_o = '0;
    assign bus.fetch_cnt_o = '0;
`endif

endmodule
